// File: rtl/powlib_busburst_pkg.sv
// Shared types for the burst bus master: FSM state encoding.
package powlib_busburst_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

endpackage

// File: rtl/powlib_busburst_addrgen.sv
// Burst address counter. With POWLIB_BUSBURST_WRAP_EN defined the count wraps
// inside an aligned 2^B_WRAPW-beat window; otherwise it increments linearly.
module powlib_busburst_addrgen #(
    parameter int B_AW    = 8,
    parameter int B_WRAPW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic [B_AW-1:0] load_addr,
    output logic [B_AW-1:0] addr
);

    logic [B_AW-1:0] addr_r;
    logic [B_AW-1:0] addr_inc_s;

`ifdef POWLIB_BUSBURST_WRAP_EN
    // Upper bits stay pinned to the command's window, low bits roll over.
    always_comb begin
        addr_inc_s = {addr_r[B_AW-1:B_WRAPW], addr_r[B_WRAPW-1:0] + B_WRAPW'(1)};
    end
`else
    logic unused_wrap_s;
    assign unused_wrap_s = ^B_WRAPW;

    // Plain modulo-2^B_AW increment.
    always_comb begin
        addr_inc_s = addr_r + B_AW'(1);
    end
`endif

    // Address register: load on command accept, advance on each accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r <= {B_AW{1'b0}};
        end else if (load) begin
            addr_r <= load_addr;
        end else if (step) begin
            addr_r <= addr_inc_s;
        end else begin
            addr_r <= addr_r;
        end
    end

    assign addr = addr_r;

endmodule

// File: rtl/powlib_busburst.sv
// Burst bus master: turns (address, length) commands plus a data stream into
// addressed bus beats. Optional wrap mode: define POWLIB_BUSBURST_WRAP_EN.
module powlib_busburst
    import powlib_busburst_pkg::*;
#(
    parameter int         B_AW    = 8,
    parameter int         B_DW    = 8,
    parameter int         LW      = 4,
    parameter int         EAR     = 0,
    parameter logic [63:0] ID     = "BUSBURST",
    parameter int         EDBG    = 0,
    parameter int         B_WRAPW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [B_AW-1:0] cmdaddr,
    input  logic [LW-1:0]   cmdlen,
    input  logic            cmdvld,
    output logic            cmdrdy,
    input  logic [B_DW-1:0] indata,
    input  logic            invld,
    output logic            inrdy,
    output logic [B_DW-1:0] wrdata,
    output logic [B_AW-1:0] wraddr,
    output logic            wrvld,
    input  logic            wrrdy,
    input  logic            wrnf,
    output logic            done
);

    state_e          state_r;
    state_e          state_nxt_s;
    logic [LW-1:0]   rem_r;
    logic [B_AW-1:0] addr_s;
    logic            cmd_hs_s;
    logic            in_hs_s;
    logic            last_r;
    logic            wrvld_r;
    logic            done_r;
    logic [B_DW-1:0] wrdata_r;
    logic [B_AW-1:0] wraddr_r;
    logic            unused_s;

    assign unused_s = ^{EAR, EDBG, ID};

    // Input is only taken when the output stage is free (or draining this cycle),
    // so a new burst's first beat can never overtake a pending last beat.
    assign cmdrdy   = (state_r == ST_IDLE) && !rst;
    assign inrdy    = (state_r == ST_BURST) && !rst && (!wrvld_r || wrrdy) && !wrnf;
    assign cmd_hs_s = cmdvld && cmdrdy;
    assign in_hs_s  = invld && inrdy;

    powlib_busburst_addrgen #(
        .B_AW    (B_AW),
        .B_WRAPW (B_WRAPW)
    ) u_addrgen (
        .clk       (clk),
        .rst       (rst),
        .load      (cmd_hs_s),
        .step      (in_hs_s),
        .load_addr (cmdaddr),
        .addr      (addr_s)
    );

    // Next-state logic for the command/burst FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_hs_s) state_nxt_s = ST_BURST;
                else          state_nxt_s = ST_IDLE;
            end
            ST_BURST: begin
                if (in_hs_s && (rem_r == {LW{1'b0}})) state_nxt_s = ST_IDLE;
                else                                  state_nxt_s = ST_BURST;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM state and remaining-beat counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            rem_r   <= {LW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (cmd_hs_s)     rem_r <= cmdlen;
            else if (in_hs_s) rem_r <= rem_r - LW'(1);
            else              rem_r <= rem_r;
        end
    end

    // Output-stage control: valid, last-beat flag and completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrvld_r <= 1'b0;
            last_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= wrvld_r && wrrdy && last_r;
            if (in_hs_s) begin
                wrvld_r <= 1'b1;
                last_r  <= (rem_r == {LW{1'b0}});
            end else if (wrrdy) begin
                wrvld_r <= 1'b0;
                last_r  <= last_r;
            end else begin
                wrvld_r <= wrvld_r;
                last_r  <= last_r;
            end
        end
    end

    // Output-stage payload; meaningless while wrvld is low, so left unreset.
    always_ff @(posedge clk) begin
        if (in_hs_s) begin
            wrdata_r <= indata;
            wraddr_r <= addr_s;
        end else begin
            wrdata_r <= wrdata_r;
            wraddr_r <= wraddr_r;
        end
    end

    assign wrvld  = wrvld_r;
    assign wrdata = wrdata_r;
    assign wraddr = wraddr_r;
    assign done   = done_r;

endmodule

// File: tb/tb_powlib_busburst.sv
// Self-checking bench for powlib_busburst: queue-based beat model checked every
// cycle, directed scenarios with literal expectations, then randomized bursts.
module tb_powlib_busburst;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] cmdaddr;
    logic [3:0] cmdlen;
    logic       cmdvld, cmdrdy;
    logic [7:0] indata;
    logic       invld, inrdy;
    logic [7:0] wrdata, wraddr;
    logic       wrvld, wrrdy, wrnf, done;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
        bit         last;
    } beat_t;

    beat_t      mq[$];
    bit         m_active = 1'b0;
    int         m_rem = 0;
    logic [7:0] m_addr = 8'h00;
    bit         m_done = 1'b0;
    bit         chk_en = 1'b0;
    bit         rand_bus = 1'b0;
    logic [7:0] log_a[$];
    logic [7:0] log_d[$];
    int         done_cnt = 0;

    powlib_busburst dut (
        .clk(clk), .rst(rst),
        .cmdaddr(cmdaddr), .cmdlen(cmdlen), .cmdvld(cmdvld), .cmdrdy(cmdrdy),
        .indata(indata), .invld(invld), .inrdy(inrdy),
        .wrdata(wrdata), .wraddr(wraddr), .wrvld(wrvld), .wrrdy(wrrdy), .wrnf(wrnf),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] next_addr(input logic [7:0] a);
        int v;
`ifdef POWLIB_BUSBURST_WRAP_EN
        v = (int'(a) / 4) * 4 + ((int'(a) % 4 + 1) % 4);
`else
        v = (int'(a) + 1) % 256;
`endif
        return 8'(v);
    endfunction

    // Reference model: a burst is a list of beats at consecutive addresses,
    // each beat sits in the single output slot until the bus accepts it.
    always @(posedge clk) begin
        bit ir, cr, dn;
        if (rst) begin
            m_active = 1'b0;
            mq.delete();
            m_done = 1'b0;
        end else begin
            ir = m_active && (mq.size() == 0 || wrrdy) && !wrnf;
            cr = !m_active;
            dn = 1'b0;
            if (mq.size() > 0 && wrrdy) begin
                dn = mq[0].last;
                void'(mq.pop_front());
            end
            if (invld && ir) begin
                mq.push_back('{a: m_addr, d: indata, last: (m_rem == 1)});
                m_addr = next_addr(m_addr);
                m_rem--;
                if (m_rem == 0) m_active = 1'b0;
            end
            if (cmdvld && cr) begin
                m_active = 1'b1;
                m_addr   = cmdaddr;
                m_rem    = int'(cmdlen) + 1;
            end
            m_done = dn;
        end
    end

    // Log of beats the DUT actually put on the bus.
    always @(posedge clk) begin
        if (!rst && wrvld === 1'b1 && wrrdy) begin
            log_a.push_back(wraddr);
            log_d.push_back(wrdata);
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmdrdy", cmdrdy, !rst && !m_active);
            chk("inrdy", inrdy, !rst && m_active && (mq.size() == 0 || wrrdy) && !wrnf);
            chk("wrvld", wrvld, mq.size() != 0);
            if (mq.size() != 0) begin
                chk("wraddr", wraddr, mq[0].a);
                chk("wrdata", wrdata, mq[0].d);
            end
            chk("done", done, m_done);
            if (done === 1'b1) done_cnt++;
        end
    end

    // Randomized bus-side backpressure when enabled.
    always @(posedge clk) begin
        #1;
        if (rand_bus) begin
            wrrdy = ($urandom_range(0, 3) != 0);
            wrnf  = ($urandom_range(0, 5) == 0);
        end
    end

    // Issue one command and stream its beats; aborts if rst is raised.
    task automatic send_burst(input logic [7:0] a, input logic [3:0] l,
                              input logic [7:0] d0, input int gap);
        logic s;
        logic rr;
        int   i;
        int   t;
        cmdaddr = a;
        cmdlen  = l;
        cmdvld  = 1'b1;
        t = 0;
        s = 1'b0;
        while (!s && t < 200) begin
            @(negedge clk);
            s = cmdrdy;
            @(posedge clk);
            #1;
            t++;
        end
        cmdvld = 1'b0;
        if (!s) chk("cmd_timeout", 32'd0, 32'd1);
        i  = 0;
        t  = 0;
        rr = 1'b0;
        while (i <= int'(l) && t < 1000) begin
            invld  = (gap == 0) || ($urandom_range(0, gap) == 0);
            indata = 8'(int'(d0) + i);
            @(negedge clk);
            s  = inrdy;
            rr = rst;
            @(posedge clk);
            #1;
            if (rr) break;
            if (invld && s) i++;
            t++;
        end
        invld = 1'b0;
        if (!rr && i <= int'(l)) chk("beat_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        int cnt;
        cnt = 0;
        for (int k = 0; k < 300 && cnt < 3; k++) begin
            @(negedge clk);
            if (!wrvld && cmdrdy) cnt++;
            else                  cnt = 0;
        end
        if (cnt < 3) chk("idle_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(input logic [7:0] a);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            if (wrvld === 1'b1 && wraddr == a) seen = 1'b1;
        end
        if (!seen) chk("wait_out_timeout", 32'd0, 32'd1);
    endtask

    task automatic chk_log(input string nm, input int idx, input logic [7:0] a, input logic [7:0] d);
        if (idx < log_a.size()) begin
            chk({nm, "_addr"}, log_a[idx], a);
            chk({nm, "_data"}, log_d[idx], d);
        end else begin
            chk({nm, "_missing"}, 32'(log_a.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        int dc;
        rst = 1'b1; cmdvld = 1'b0; invld = 1'b0; wrrdy = 1'b1; wrnf = 1'b0;
        cmdaddr = 8'h00; cmdlen = 4'h0; indata = 8'h00;
        @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_wrvld", wrvld, 32'd0);
        chk("rst_done", done, 32'd0);
        chk("rst_cmdrdy", cmdrdy, 32'd0);
        chk("rst_inrdy", inrdy, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single beat.
        log_a.delete(); log_d.delete(); dc = done_cnt;
        send_burst(8'h10, 4'd0, 8'hA5, 0);
        wait_idle();
        chk("single_cnt", 32'(log_a.size()), 32'd1);
        chk_log("single", 0, 8'h10, 8'hA5);
        chk("single_done", 32'(done_cnt - dc), 32'd1);
        chk("single_cmdrdy", cmdrdy, 32'd1);

        // Streaming with a 3-cycle stall on beat 2.
        log_a.delete(); log_d.delete(); dc = done_cnt;
        fork
            send_burst(8'h20, 4'd3, 8'h01, 0);
            begin
                wait_out(8'h20);
                @(posedge clk); #1;
                wrrdy = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_addr", wraddr, 32'h21);
                    chk("bp_data", wrdata, 32'h02);
                    chk("bp_inrdy", inrdy, 32'd0);
                    @(posedge clk); #1;
                end
                wrrdy = 1'b1;
            end
        join
        wait_idle();
        chk("bp_cnt", 32'(log_a.size()), 32'd4);
        for (int k = 0; k < 4; k++) chk_log("bp", k, 8'(8'h20 + k), 8'(8'h01 + k));
        chk("bp_done", 32'(done_cnt - dc), 32'd1);

        // Nearly full mid-burst.
        log_a.delete(); log_d.delete();
        fork
            send_burst(8'h30, 4'd3, 8'h11, 0);
            begin
                wait_out(8'h30);
                @(posedge clk); #1;
                wrnf = 1'b1;
                @(negedge clk);
                chk("nf_inrdy", inrdy, 32'd0);
                chk("nf_pending", wrvld, 32'd1);
                @(negedge clk);
                chk("nf_drained", wrvld, 32'd0);
                @(posedge clk); #1;
                @(posedge clk); #1;
                wrnf = 1'b0;
            end
        join
        wait_idle();
        for (int k = 0; k < 4; k++) chk_log("nf", k, 8'(8'h30 + k), 8'(8'h11 + k));

        // Address wrap.
        log_a.delete(); log_d.delete();
        send_burst(8'hFE, 4'd3, 8'h40, 0);
        wait_idle();
`ifdef POWLIB_BUSBURST_WRAP_EN
        chk_log("wrap0", 0, 8'hFE, 8'h40);
        chk_log("wrap1", 1, 8'hFF, 8'h41);
        chk_log("wrap2", 2, 8'hFC, 8'h42);
        chk_log("wrap3", 3, 8'hFD, 8'h43);
`else
        chk_log("wrap0", 0, 8'hFE, 8'h40);
        chk_log("wrap1", 1, 8'hFF, 8'h41);
        chk_log("wrap2", 2, 8'h00, 8'h42);
        chk_log("wrap3", 3, 8'h01, 8'h43);
`endif

        // Reset mid-burst.
        dc = done_cnt;
        fork
            send_burst(8'h40, 4'd3, 8'h60, 0);
            begin
                wait_out(8'h41);
                @(posedge clk); #1;
                rst = 1'b1;
                @(negedge clk);
                chk("rstmb_cmdrdy", cmdrdy, 32'd0);
                @(negedge clk);
                chk("rstmb_wrvld", wrvld, 32'd0);
                chk("rstmb_done", done, 32'd0);
                @(posedge clk); #1;
                rst = 1'b0;
                @(negedge clk);
                chk("rstmb_cmdrdy_after", cmdrdy, 32'd1);
                @(posedge clk); #1;
            end
        join
        chk("rstmb_no_done", 32'(done_cnt - dc), 32'd0);
        log_a.delete(); log_d.delete(); dc = done_cnt;
        send_burst(8'h50, 4'd1, 8'h77, 0);
        wait_idle();
        chk("post_rst_cnt", 32'(log_a.size()), 32'd2);
        chk_log("post_rst0", 0, 8'h50, 8'h77);
        chk_log("post_rst1", 1, 8'h51, 8'h78);
        chk("post_rst_done", 32'(done_cnt - dc), 32'd1);

        // Randomized bursts under random backpressure.
        rand_bus = 1'b1;
        for (int b = 0; b < 40; b++) begin
            send_burst(8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)),
                       8'($urandom_range(0, 255)), $urandom_range(0, 2));
        end
        rand_bus = 1'b0;
        @(posedge clk); #1;
        wrrdy = 1'b1;
        wrnf  = 1'b0;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/powlib_busburst.md
Name: powlib_busburst

Overview:
- Upstream bus master stage that feeds one write port of the bus crossbar (or a bus FIFO).
- Accepts a burst command (start address, beat count) and a plain data stream.
- Emits one addressed bus transaction per data beat, with the address incrementing per beat.
- Registered output stage honours the downstream ready and nearly-full signals; a single-cycle done pulse marks burst completion.

Parameters:
- B_AW, 8, bus address width.
- B_DW, 8, bus data width.
- LW, 4, command length field width; a burst is cmdlen+1 beats (1..2^LW).
- EAR, 0, enable asynchronous reset on internal flipflops (must remain 0 for this block).
- ID, "BUSBURST", string identifier.
- EDBG, 0, enable debug prints.
- B_WRAPW, 2, log2 of the wrap window in beats; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cmdaddr  in  B_AW  burst start address.
- cmdlen  in  LW  beats minus 1.
- cmdvld  in  1  command valid.
- cmdrdy  out  1  command ready.
- indata  in  B_DW  data beat.
- invld  in  1  data valid.
- inrdy  out  1  data ready.
- wrdata  out  B_DW  bus data.
- wraddr  out  B_AW  bus address.
- wrvld  out  1  bus valid.
- wrrdy  in  1  bus ready.
- wrnf  in  1  bus nearly full.
- done  out  1  one-cycle pulse when the last beat of a burst transfers on the bus.

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, cmdrdy=0 during reset, wrvld=0, done=0, inrdy=0. wrdata and wraddr are unreset (don't-care).
- Transfer rule: a handshake occurs on any interface when vld&&rdy at a rising edge. wrvld must not depend combinationally on wrrdy.
- States:
  - IDLE: cmdrdy=1, inrdy=0.
  - On cmdvld&&cmdrdy: load addr_cnt=cmdaddr, rem=cmdlen, go to BURST.
- BURST:
  - cmdrdy=0.
  - inrdy = (!wrvld || wrrdy) && !wrnf.
  - On an input handshake: next cycle wrvld=1, wrdata=indata, wraddr=addr_cnt, last_q=(rem==0).
  - Then addr_cnt+=1 (modulo 2^B_AW, wraps 0xFF->0x00 at default width) and rem-=1.
  - If rem==0 at the handshake, go to IDLE.
- Output stage:
  - If wrvld && !wrrdy, hold wrdata, wraddr and last_q stable.
  - If wrvld && wrrdy with no new input beat, next cycle wrvld=0.
  - Back-to-back throughput is 1 beat per cycle while wrrdy=1 and wrnf=0.
- Latency: input handshake to wrvld = 1 cycle.
- done=1 for exactly the cycle after a bus handshake where last_q=1.
- A new command may be accepted in IDLE while the previous last beat is still pending in the output stage. Its first beat cannot overtake, because inrdy requires the output stage to be free.
- wrnf=1 blocks new input beats only. A beat already in the output stage still transfers when wrrdy=1.
- Reset mid-burst: the pending output beat is discarded, wrvld=0, state=IDLE, and no done pulse is generated.
- invld while in IDLE is ignored (inrdy=0).
- Simultaneous events: on the cycle of the last input handshake, state goes to IDLE, so cmdrdy=1 the following cycle.

Optional Feature:
- Macro: POWLIB_BUSBURST_WRAP_EN.
- Defined: the address increments only within an aligned 2^B_WRAPW-beat window. The upper B_AW-B_WRAPW bits stay fixed from cmdaddr and the low B_WRAPW bits wrap modulo 2^B_WRAPW.
- Undefined: linear increment modulo 2^B_AW, and the B_WRAPW parameter is ignored.

Decomposition:
- State encodings (IDLE=1'b0, BURST=1'b1) go as named constants in the shared powlib_std.vh include, alongside POWLIB_BW.
- Output-stage registers use the existing powlib_flipflop.
- One natural sub-module: powlib_busburst_addrgen (address counter plus wrap logic, selected by the macro), kept in powlib_bus.v.
- The remaining FSM stays flat.

Test Plan:
- Single beat: cmdaddr=0x10, cmdlen=0, indata=0xA5, wrrdy=1 -> one transfer with wraddr=0x10 and wrdata=0xA5 one cycle after the input handshake; done pulses the next cycle; cmdrdy=1 again.
- Streaming: cmdaddr=0x20, cmdlen=3, data 0x01..0x04 back-to-back, wrrdy=1 -> wraddr 0x20,0x21,0x22,0x23 on 4 consecutive cycles; done once after 0x23.
- Backpressure: same burst with wrrdy=0 for 3 cycles on beat 2 -> wraddr and wrdata held at 0x21/0x02, inrdy=0, no beat lost or duplicated.
- Nearly full: wrnf=1 mid-burst -> inrdy=0 while the pending beat still drains; resumes when wrnf=0 with the correct next address.
- Address wrap: cmdaddr=0xFE, cmdlen=3 -> 0xFE,0xFF,0x00,0x01 without the macro. With POWLIB_BUSBURST_WRAP_EN and B_WRAPW=2 -> 0xFE,0xFF,0xFC,0xFD.
- Reset mid-burst: rst=1 after beat 2 of a 4-beat burst -> wrvld=0 next cycle, no done, cmdrdy=1 after rst deasserts; a new burst then completes correctly.
